// File: rtl/axis_dds_sin_gen.sv
// DDS sine source: phase accumulator, quarter-wave LUT, amplitude scaling, AXI-Stream master.
// Four-register pipeline under one global advance (ce); samples carry their own amplitude.
module axis_dds_sin_gen #(
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int AMP_WIDTH      = 16
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic                   enable,
  input  logic                   cfg_load,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_off,
  input  logic [AMP_WIDTH-1:0]   cfg_amp,
  input  logic                   cfg_sync,
  output logic [DATA_WIDTH-1:0]  m_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic                   m_axis_data_tlast
);

  localparam int STAGES = 3;
  localparam int LA     = LUT_ADDR_WIDTH;
  localparam int Q      = 1 << (LA - 2);
  localparam int MW     = DATA_WIDTH - 1;            // LUT magnitude width
  localparam int PRW    = DATA_WIDTH + AMP_WIDTH + 1; // signed product width
  localparam int YW     = PRW - (AMP_WIDTH - 1);     // width after rescale shift
  localparam logic signed [PRW-1:0] HALF  = PRW'(1) << (AMP_WIDTH - 2);
  localparam logic signed [YW-1:0]  Y_MAX = YW'((1 << (DATA_WIDTH - 1)) - 1);

  // Quarter-wave table entry, computed at elaboration
  function automatic logic [MW-1:0] lut_val(input int j);
    real v;
    v = (2.0 ** (DATA_WIDTH - 1) - 1.0) *
        $sin(3.14159265358979323846 / 2.0 * real'(j) / real'(Q));
    return MW'($rtoi(v + 0.5));
  endfunction

  logic [MW-1:0] lut_rom [0:Q];
  for (genvar j = 0; j <= Q; j++) begin : g_lut
    localparam logic [MW-1:0] TV = lut_val(j);
    assign lut_rom[j] = TV;
  end

  logic                   ce, issue;
  logic [STAGES:0]        vld_pipe;
  logic [PHASE_WIDTH-1:0] acc, act_inc, act_off;
  logic [AMP_WIDTH-1:0]   act_amp;
  logic [PHASE_WIDTH:0]   acc_sum;

  assign ce      = !m_axis_data_tvalid || m_axis_data_tready;
  assign issue   = ce && enable;
  assign acc_sum = {1'b0, acc} + {1'b0, act_inc};
  assign m_axis_data_tvalid = vld_pipe[STAGES];

  // Active config and accumulator; cfg loads and sync-clears even while stalled
  always_ff @(posedge aclk) begin
    if (arst) begin
      act_inc <= '0;
      act_off <= '0;
      act_amp <= '0;
      acc     <= '0;
    end else begin
      if (cfg_load) begin
        act_inc <= cfg_phase_inc;
        act_off <= cfg_phase_off;
        act_amp <= cfg_amp;
      end
      if (cfg_load && cfg_sync) acc <= '0;
      else if (issue)           acc <= acc_sum[PHASE_WIDTH-1:0];
    end
  end

  // Valid shift register; a new valid enters only when enable is high
  always_ff @(posedge aclk) begin
    if (arst)    vld_pipe <= '0;
    else if (ce) vld_pipe <= {vld_pipe[STAGES-1:0], enable};
  end

  // Stage 0: capture lookup phase (acc + offset), wrap flag and amplitude of the issued sample
  logic [LA-1:0]        s0_p;
  logic                 s0_last;
  logic [AMP_WIDTH-1:0] s0_amp;
  always_ff @(posedge aclk) begin
    if (arst) begin
      s0_p    <= '0;
      s0_last <= 1'b0;
      s0_amp  <= '0;
    end else if (ce) begin
      s0_p    <= LA'((acc + act_off) >> (PHASE_WIDTH - LA));
      s0_last <= acc_sum[PHASE_WIDTH];
      s0_amp  <= act_amp;
    end
  end

  // Odd quadrants read the table mirrored (Q-k); upper quadrant bit selects the sign
  logic [LA-2:0] lut_idx;
  assign lut_idx = s0_p[LA-2] ? (LA-1)'(Q) - {1'b0, s0_p[LA-3:0]} : {1'b0, s0_p[LA-3:0]};

  // Stage 1: registered table read
  logic [MW-1:0]        s1_mag;
  logic                 s1_neg, s1_last;
  logic [AMP_WIDTH-1:0] s1_amp;
  always_ff @(posedge aclk) begin
    if (arst) begin
      s1_mag  <= '0;
      s1_neg  <= 1'b0;
      s1_last <= 1'b0;
      s1_amp  <= '0;
    end else if (ce) begin
      s1_mag  <= lut_rom[lut_idx];
      s1_neg  <= s0_p[LA-1];
      s1_last <= s0_last;
      s1_amp  <= s0_amp;
    end
  end

  logic signed [DATA_WIDTH-1:0] s_val;
  logic signed [PRW-1:0]        s_ext, a_ext;
  assign s_val = s1_neg ? -$signed({1'b0, s1_mag}) : $signed({1'b0, s1_mag});
  assign s_ext = PRW'(s_val);
  assign a_ext = PRW'({1'b0, s1_amp});

  // Stage 2: signed sample times unsigned amplitude, full width
  logic signed [PRW-1:0] s2_prod;
  logic                  s2_last;
  always_ff @(posedge aclk) begin
    if (arst) begin
      s2_prod <= '0;
      s2_last <= 1'b0;
    end else if (ce) begin
      s2_prod <= s_ext * a_ext;
      s2_last <= s1_last;
    end
  end

  // Round-half-up rescale by 2^(AMP_WIDTH-1), then symmetric saturation
  logic signed [PRW-1:0] rnd, shr;
  logic signed [YW-1:0]  y_full, y_sat;
  assign rnd    = s2_prod + HALF;
  assign shr    = rnd >>> (AMP_WIDTH - 1);
  assign y_full = shr[YW-1:0];

  // Saturation clamp
  always_comb begin
    y_sat = y_full;
    if (y_full > Y_MAX)       y_sat = Y_MAX;
    else if (y_full < -Y_MAX) y_sat = -Y_MAX;
  end

  // Stage 3: output register, held while downstream stalls
  always_ff @(posedge aclk) begin
    if (arst) begin
      m_axis_data_tdata <= '0;
      m_axis_data_tlast <= 1'b0;
    end else if (ce) begin
      m_axis_data_tdata <= y_sat[DATA_WIDTH-1:0];
      m_axis_data_tlast <= s2_last;
    end
  end

endmodule

// File: tb/tb_axis_dds_sin_gen.sv
// Self-checking bench for axis_dds_sin_gen: directed steps plus a phase/sine reference model.
module tb_axis_dds_sin_gen;

  localparam real PI = 3.14159265358979323846;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  logic        aclk = 1'b0;
  logic        arst, enable, cfg_load, cfg_sync;
  logic [31:0] cfg_phase_inc, cfg_phase_off;
  logic [15:0] cfg_amp;
  logic [15:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid, m_axis_data_tready, m_axis_data_tlast;

  int total = 0;
  int bad   = 0;

  // reference model state: sample index since last sync, active settings
  longint unsigned m_n, m_inc, m_off;
  int              m_amp;

  axis_dds_sin_gen dut (
    .aclk(aclk), .arst(arst), .enable(enable), .cfg_load(cfg_load),
    .cfg_phase_inc(cfg_phase_inc), .cfg_phase_off(cfg_phase_off),
    .cfg_amp(cfg_amp), .cfg_sync(cfg_sync),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
    .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp, input int tol);
    total++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Sample n: phase = off + n*inc mod 2^32; value = 32767*sin(2*pi*phase/2^32) on a 1024-point grid
  task automatic ref_next(output longint d, output longint l);
    longint unsigned acc, ph;
    longint s, y;
    int p;
    real v;
    acc = (m_n * m_inc) & MASK;
    ph  = (acc + m_off) & MASK;
    l   = longint'((acc + m_inc) >> 32);
    p   = int'(ph >> 22);
    v   = 32767.0 * $sin(2.0 * PI * real'(p) / 1024.0);
    s   = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    y   = (s * longint'(m_amp) + 64'sd16384) >>> 15;
    if (y > 32767)  y = 32767;
    if (y < -32767) y = -32767;
    d = y;
    m_n++;
  endtask

  // Called at a negedge; returns at a negedge after one handshake. Checks hold while stalled.
  task automatic get_sample(input bit rnd, output longint d, output longint l, output bit ok);
    bit held = 1'b0;
    logic [15:0] hd = '0;
    logic hl = 1'b0;
    ok = 1'b0; d = 0; l = 0;
    for (int i = 0; i < 200; i++) begin
      if (held) begin
        chk("hold_valid", m_axis_data_tvalid, 1);
        chk("hold_data", $signed(m_axis_data_tdata), $signed(hd));
        chk("hold_last", m_axis_data_tlast, hl);
      end
      m_axis_data_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_axis_data_tvalid && m_axis_data_tready) begin
        d  = longint'($signed(m_axis_data_tdata));
        l  = longint'(m_axis_data_tlast);
        ok = 1'b1;
        @(negedge aclk);
        break;
      end
      held = m_axis_data_tvalid;
      hd   = m_axis_data_tdata;
      hl   = m_axis_data_tlast;
      @(negedge aclk);
    end
  endtask

  task automatic expect_next(input string tag, input bit rnd, input int tol, output longint d);
    longint l, ed, el;
    bit ok;
    get_sample(rnd, d, l, ok);
    chk({tag, "_handshake"}, ok, 1);
    ref_next(ed, el);
    if (ok) begin
      chk_tol({tag, "_data"}, d, ed, tol);
      chk({tag, "_last"}, l, el);
    end
  endtask

  task automatic load(input longint unsigned inc, input longint unsigned off, input int amp, input bit sync);
    cfg_phase_inc = inc[31:0];
    cfg_phase_off = off[31:0];
    cfg_amp       = amp[15:0];
    cfg_sync      = sync;
    cfg_load      = 1'b1;
    @(negedge aclk);
    cfg_load = 1'b0;
    cfg_sync = 1'b0;
    m_inc = inc; m_off = off; m_amp = amp;
    if (sync) m_n = 0;
  endtask

  // enable rises now; tvalid must appear exactly 4 cycles later
  task automatic start_and_check_latency(input string tag);
    m_axis_data_tready = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge aclk);
      chk({tag, "_latency"}, m_axis_data_tvalid, (k == 4) ? 1 : 0);
    end
  endtask

  task automatic drain(input string tag);
    longint d;
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m_axis_data_tready = 1'b1;
      if (m_axis_data_tvalid) expect_next(tag, 1'b0, 0, d);
      else @(negedge aclk);
    end
    chk({tag, "_empty"}, m_axis_data_tvalid, 0);
  endtask

  task automatic const_run(input string tag, input longint c0, input longint c1,
                           input longint c2, input longint c3, input int n);
    longint tab[4];
    longint d;
    tab[0] = c0; tab[1] = c1; tab[2] = c2; tab[3] = c3;
    for (int i = 0; i < n; i++) begin
      expect_next(tag, 1'b0, 0, d);
      chk({tag, "_const"}, d, tab[i % 4]);
    end
  endtask

  initial begin
    longint d, hold_d, hold_l;
    arst = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_sync = 1'b0;
    cfg_phase_inc = '0; cfg_phase_off = '0; cfg_amp = '0;
    m_axis_data_tready = 1'b1;
    m_n = 0; m_inc = 0; m_off = 0; m_amp = 0;

    // reset held three cycles, then one idle cycle after release
    repeat (3) begin
      @(negedge aclk);
      chk("rst_valid", m_axis_data_tvalid, 0);
      chk("rst_data", m_axis_data_tdata, 0);
      chk("rst_last", m_axis_data_tlast, 0);
    end
    arst = 1'b0;
    @(negedge aclk);
    chk("post_rst_valid", m_axis_data_tvalid, 0);
    chk("post_rst_data", m_axis_data_tdata, 0);
    chk("post_rst_last", m_axis_data_tlast, 0);

    // quarter-period tone at full scale
    load(64'd1 << 30, 0, 32768, 1'b1);
    start_and_check_latency("t2");
    const_run("t2", 0, 32767, 0, -32767, 8);

    // 10-cycle stall mid-stream, then randomised backpressure
    m_axis_data_tready = 1'b0;
    hold_d = longint'($signed(m_axis_data_tdata));
    hold_l = longint'(m_axis_data_tlast);
    chk("stall_entry_valid", m_axis_data_tvalid, 1);
    repeat (10) begin
      @(negedge aclk);
      chk("stall_valid", m_axis_data_tvalid, 1);
      chk("stall_data", $signed(m_axis_data_tdata), hold_d);
      chk("stall_last", m_axis_data_tlast, hold_l);
    end
    for (int i = 0; i < 1000; i++) expect_next("rnd", 1'b1, 0, d);
    drain("t4_drain");

    // amplitude scaling and saturation
    load(64'd1 << 30, 0, 16384, 1'b1);
    enable = 1'b1;
    const_run("amp_half", 0, 16384, 0, -16383, 8);
    drain("amp_half_drain");
    load(64'd1 << 30, 0, 65535, 1'b1);
    enable = 1'b1;
    const_run("amp_max", 0, 32767, 0, -32767, 8);
    drain("amp_max_drain");

    // one LUT point per sample, two full periods
    load(64'd1 << 22, 0, 32768, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 2048; i++) expect_next("fine", 1'b0, 1, d);
    drain("fine_drain");

    // zero tuning word: constant output, never a wrap
    load(0, 64'd3 << 30, 32768, 1'b1);
    enable = 1'b1;
    const_run("inc0", -32767, -32767, -32767, -32767, 16);
    drain("inc0_drain");

    // phase offset, then reset mid-stream and restart
    load(64'd1 << 30, 64'd1 << 30, 32768, 1'b1);
    start_and_check_latency("off");
    const_run("off", 32767, 0, -32767, 0, 6);
    arst = 1'b1;
    @(negedge aclk);
    chk("midrst_valid", m_axis_data_tvalid, 0);
    chk("midrst_data", m_axis_data_tdata, 0);
    arst = 1'b0;
    enable = 1'b0;
    @(negedge aclk);
    chk("midrst_idle_valid", m_axis_data_tvalid, 0);
    load(64'd1 << 30, 64'd1 << 30, 32768, 1'b1);
    start_and_check_latency("restart");
    const_run("restart", 32767, 0, -32767, 0, 8);
    drain("restart_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
